// File: rtl/seq_muldiv_alu.sv
// Sequential integer ALU with valid/ready handshakes on both sides.
// Add/sub finish at the accept edge; multiply/divide iterate one bit per cycle on a shared 2N-bit accumulator.
module seq_muldiv_alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_op,
    input  logic                  i_signed,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic                  o_ovf,
    output logic                  o_zero,
    output logic                  o_dbz
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_MULH = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_REM  = 3'd5;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic [2*N-1:0]  acc_reg, acc_next;
    logic [N-1:0]    mag_a_reg, mag_a_next;
    logic [N-1:0]    mag_b_reg, mag_b_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            sign_a_reg, sign_a_next;
    logic            sign_b_reg, sign_b_next;
    logic            signed_reg, signed_next;
    logic [2:0]      op_reg, op_next;
    logic [N-1:0]    q_reg, q_next;
    logic            ovf_reg, ovf_next;
    logic            zero_reg, zero_next;
    logic            dbz_reg, dbz_next;

    // Single-cycle add/sub, evaluated on the live inputs at the accept edge
    logic [N:0]   add_full, sub_full;
    logic         add_sovf, sub_sovf;
    logic         in_sign_a, in_sign_b;
    logic [N-1:0] in_mag_a, in_mag_b;

    assign add_full  = {1'b0, i_a} + {1'b0, i_b};
    assign sub_full  = {1'b0, i_a} - {1'b0, i_b};
    assign add_sovf  = (i_a[N-1] == i_b[N-1]) && (add_full[N-1] != i_a[N-1]);
    assign sub_sovf  = (i_a[N-1] != i_b[N-1]) && (sub_full[N-1] != i_a[N-1]);
    assign in_sign_a = i_signed & i_a[N-1];
    assign in_sign_b = i_signed & i_b[N-1];
    assign in_mag_a  = in_sign_a ? (N'(0) - i_a) : i_a;
    assign in_mag_b  = in_sign_b ? (N'(0) - i_b) : i_b;

    // Shift-add step: low half holds the remaining multiplier bits
    logic [N:0]     mul_hi_sum;
    logic [2*N-1:0] mul_step;
    assign mul_hi_sum = {1'b0, acc_reg[2*N-1:N]} + {1'b0, (acc_reg[0] ? mag_a_reg : N'(0))};
    assign mul_step   = {mul_hi_sum, acc_reg[N-1:1]};

    // Restoring step: upper half is the partial remainder, lower half collects quotient bits
    logic [N:0]     div_shift, div_trial;
    logic [2*N-1:0] div_step;
    assign div_shift = acc_reg[2*N-1:N-1];
    assign div_trial = div_shift - {1'b0, mag_b_reg};
    assign div_step  = div_trial[N] ? {div_shift[N-1:0], acc_reg[N-2:0], 1'b0}
                                    : {div_trial[N-1:0], acc_reg[N-2:0], 1'b1};

    // Sign fix-up of the finished magnitudes
    logic           res_neg;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quot_fix, rem_fix;
    logic           mul_sovf, mul_uovf, div_ovf;
    assign res_neg  = sign_a_reg ^ sign_b_reg;
    assign prod_fix = res_neg ? ((2*N)'(0) - acc_reg) : acc_reg;
    assign quot_fix = res_neg ? (N'(0) - acc_reg[N-1:0]) : acc_reg[N-1:0];
    assign rem_fix  = sign_a_reg ? (N'(0) - acc_reg[2*N-1:N]) : acc_reg[2*N-1:N];
    assign mul_sovf = !((&prod_fix[2*N-1:N-1]) || !(|prod_fix[2*N-1:N-1]));
    assign mul_uovf = |prod_fix[2*N-1:N];
    // Only MIN / -1 yields a positive quotient of magnitude 2^(N-1)
    assign div_ovf  = signed_reg && !res_neg && acc_reg[N-1];

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mag_a_next  = mag_a_reg;
        mag_b_next  = mag_b_reg;
        cnt_next    = cnt_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
        signed_next = signed_reg;
        op_next     = op_reg;
        q_next      = q_reg;
        ovf_next    = ovf_reg;
        zero_next   = zero_reg;
        dbz_next    = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    sign_a_next = in_sign_a;
                    sign_b_next = in_sign_b;
                    mag_a_next  = in_mag_a;
                    mag_b_next  = in_mag_b;
                    signed_next = i_signed;
                    op_next     = i_op;
                    cnt_next    = '0;
                    dbz_next    = 1'b0;
                    ovf_next    = 1'b0;
                    case (i_op)
                        OP_ADD: begin
                            q_next     = add_full[N-1:0];
                            ovf_next   = i_signed ? add_sovf : add_full[N];
                            zero_next  = (add_full[N-1:0] == '0);
                            state_next = DONE;
                        end
                        OP_SUB: begin
                            q_next     = sub_full[N-1:0];
                            ovf_next   = i_signed ? sub_sovf : sub_full[N];
                            zero_next  = (sub_full[N-1:0] == '0);
                            state_next = DONE;
                        end
                        OP_MUL, OP_MULH: begin
                            acc_next   = {N'(0), in_mag_b};
                            state_next = MUL;
                        end
                        OP_DIV, OP_REM: begin
                            if (i_b == '0) begin
                                q_next     = (i_op == OP_DIV) ? {N{1'b1}} : i_a;
                                zero_next  = (i_op == OP_REM) && (i_a == '0);
                                dbz_next   = 1'b1;
                                state_next = DONE;
                            end else begin
                                acc_next   = {N'(0), in_mag_a};
                                state_next = DIV;
                            end
                        end
                        default: begin
                            q_next     = '0;
                            zero_next  = 1'b1;
                            state_next = DONE;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_next = mul_step;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(N-1)) state_next = FIX;
            end
            DIV: begin
                acc_next = div_step;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(N-1)) state_next = FIX;
            end
            FIX: begin
                case (op_reg)
                    OP_MUL: begin
                        q_next   = prod_fix[N-1:0];
                        ovf_next = signed_reg ? mul_sovf : mul_uovf;
                    end
                    OP_MULH: q_next = prod_fix[2*N-1:N];
                    OP_DIV: begin
                        q_next   = quot_fix;
                        ovf_next = div_ovf;
                    end
                    default: q_next = rem_fix;
                endcase
                zero_next = 1'b0;
                case (op_reg)
                    OP_MUL:  zero_next = (prod_fix[N-1:0] == '0);
                    OP_MULH: zero_next = (prod_fix[2*N-1:N] == '0);
                    OP_DIV:  zero_next = (quot_fix == '0);
                    default: zero_next = (rem_fix == '0);
                endcase
                state_next = DONE;
            end
            DONE: begin
                if (i_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mag_a_reg  <= '0;
            mag_b_reg  <= '0;
            cnt_reg    <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            signed_reg <= 1'b0;
            op_reg     <= '0;
            q_reg      <= '0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mag_a_reg  <= mag_a_next;
            mag_b_reg  <= mag_b_next;
            cnt_reg    <= cnt_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            signed_reg <= signed_next;
            op_reg     <= op_next;
            q_reg      <= q_next;
            ovf_reg    <= ovf_next;
            zero_reg   <= zero_next;
            dbz_reg    <= dbz_next;
        end
    end

    assign o_ready = (state_reg == IDLE);
    assign o_valid = (state_reg == DONE);
    assign o_q     = q_reg;
    assign o_ovf   = ovf_reg;
    assign o_zero  = zero_reg;
    assign o_dbz   = dbz_reg;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Bench for seq_muldiv_alu at N=8: directed cases, reset mid-operation, then random traffic
// compared against an integer-arithmetic reference model.
module tb_seq_muldiv_alu;
    localparam int N = 8;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_op;
    logic         i_signed;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_q;
    logic         o_ovf;
    logic         o_zero;
    logic         o_dbz;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_muldiv_alu #(.DATA_WIDTH(N)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_signed(i_signed), .i_a(i_a), .i_b(i_b),
        .o_valid(o_valid), .i_ready(i_ready), .o_q(o_q), .o_ovf(o_ovf),
        .o_zero(o_zero), .o_dbz(o_dbz)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic void model(input logic [2:0] op, input bit sg, input logic [N-1:0] a,
                                  input logic [N-1:0] b, output logic [N-1:0] q,
                                  output bit ovf, output bit dbz, output int lat);
        int sa, sb, r;
        sa  = sg ? int'($signed(a)) : int'(a);
        sb  = sg ? int'($signed(b)) : int'(b);
        q   = '0;
        ovf = 0;
        dbz = 0;
        lat = 1;
        case (op)
            3'd0: begin
                r = sa + sb; q = r[7:0];
                ovf = sg ? (r < -128 || r > 127) : (r > 255);
            end
            3'd1: begin
                r = sa - sb; q = r[7:0];
                ovf = sg ? (r < -128 || r > 127) : (r < 0);
            end
            3'd2: begin
                r = sa * sb; q = r[7:0]; lat = N + 2;
                ovf = sg ? (r < -128 || r > 127) : (r > 255);
            end
            3'd3: begin
                r = sa * sb; q = r[15:8]; lat = N + 2;
            end
            3'd4, 3'd5: begin
                if (b == 0) begin
                    dbz = 1;
                    q = (op == 3'd4) ? 8'hFF : a;
                end else begin
                    lat = N + 2;
                    if (sg && sa == -128 && sb == -1) begin
                        q   = (op == 3'd4) ? 8'h80 : 8'h00;
                        ovf = (op == 3'd4);
                    end else begin
                        r = (op == 3'd4) ? (sa / sb) : (sa % sb);
                        q = r[7:0];
                    end
                end
            end
            default: q = '0;
        endcase
    endfunction

    task automatic do_txn(input logic [2:0] op, input bit sg, input logic [N-1:0] a,
                          input logic [N-1:0] b, input int hold, input string tag);
        logic [N-1:0] eq;
        bit           eovf, edbz;
        int           elat, lat;
        model(op, sg, a, b, eq, eovf, edbz, elat);
        chk({tag, " ready_before"}, o_ready, 1);
        i_valid = 1; i_op = op; i_signed = sg; i_a = a; i_b = b; i_ready = 0;
        @(posedge i_clk); #1;
        // Scramble inputs after accept; the result must not depend on them
        i_valid = 0; i_op = 3'($urandom); i_signed = 1'($urandom);
        i_a = N'($urandom); i_b = N'($urandom);
        lat = 1;
        while (o_valid !== 1'b1 && lat < 64) begin
            @(posedge i_clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " q"}, o_q, eq);
        chk({tag, " ovf"}, o_ovf, eovf);
        chk({tag, " zero"}, o_zero, (eq == 0));
        chk({tag, " dbz"}, o_dbz, edbz);
        chk({tag, " ready_done"}, o_ready, 0);
        i_valid = 1;
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk); #1;
            chk({tag, " hold_valid"}, o_valid, 1);
            chk({tag, " hold_ready"}, o_ready, 0);
            chk({tag, " hold_q"}, {o_q, o_ovf, o_zero, o_dbz}, {eq, eovf, (eq == 0), edbz});
        end
        i_ready = 1;
        @(posedge i_clk); #1;
        i_ready = 0; i_valid = 0;
        chk({tag, " valid_cleared"}, o_valid, 0);
        chk({tag, " ready_after"}, o_ready, 1);
        $display("txn %s op=%0d s=%0d a=%02h b=%02h -> q=%02h ovf=%0d zero=%0d dbz=%0d lat=%0d",
                 tag, op, sg, a, b, o_q, o_ovf, o_zero, o_dbz, lat);
    endtask

    initial begin
        i_rst = 1; i_valid = 0; i_op = 0; i_signed = 0; i_a = 0; i_b = 0; i_ready = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset valid", o_valid, 0);
        chk("reset q", o_q, 0);
        chk("reset flags", {o_ovf, o_zero, o_dbz}, 3'b000);
        i_rst = 0;
        @(posedge i_clk); #1;
        chk("reset ready", o_ready, 1);

        do_txn(3'd0, 1, 8'h64, 8'h32, 0, "add_s_ovf");
        do_txn(3'd0, 0, 8'hF0, 8'h20, 0, "add_u_carry");
        do_txn(3'd1, 0, 8'h05, 8'h07, 0, "sub_u_borrow");
        do_txn(3'd1, 1, 8'h80, 8'h01, 0, "sub_s_ovf");
        do_txn(3'd2, 1, 8'hF9, 8'h09, 0, "mul_s");
        do_txn(3'd3, 1, 8'hF9, 8'h09, 0, "mulh_s");
        do_txn(3'd2, 0, 8'h10, 8'h10, 0, "mul_u_ovf");
        do_txn(3'd3, 0, 8'hFF, 8'hFF, 0, "mulh_u");
        do_txn(3'd2, 1, 8'h80, 8'h80, 0, "mul_min_min");
        do_txn(3'd4, 1, 8'hF9, 8'h02, 0, "div_s");
        do_txn(3'd5, 1, 8'hF9, 8'h02, 0, "rem_s");
        do_txn(3'd4, 0, 8'd200, 8'd7, 0, "div_u");
        do_txn(3'd5, 0, 8'd200, 8'd7, 0, "rem_u");
        do_txn(3'd4, 1, 8'h80, 8'hFF, 0, "div_min_m1");
        do_txn(3'd5, 1, 8'h80, 8'hFF, 0, "rem_min_m1");
        do_txn(3'd4, 0, 8'h2A, 8'h00, 0, "div_by_zero");
        do_txn(3'd5, 1, 8'h2A, 8'h00, 0, "rem_by_zero");
        do_txn(3'd6, 1, 8'h12, 8'h34, 0, "reserved");
        do_txn(3'd2, 1, 8'h03, 8'h05, 5, "backpressure");
        do_txn(3'd0, 0, 8'h01, 8'h02, 0, "after_bp");

        // Reset pulse four cycles into a multiply
        i_valid = 1; i_op = 3'd2; i_signed = 0; i_a = 8'h0F; i_b = 8'h0F;
        @(posedge i_clk); #1;
        i_valid = 0;
        repeat (4) @(posedge i_clk);
        #1;
        i_rst = 1;
        #1;
        chk("midrst valid", o_valid, 0);
        chk("midrst q", o_q, 0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 0;
        @(posedge i_clk); #1;
        chk("midrst ready", o_ready, 1);
        chk("midrst valid_after", o_valid, 0);
        do_txn(3'd0, 0, 8'h01, 8'h01, 0, "add_after_rst");

        for (int t = 0; t < 200; t++) begin
            logic [2:0]   op;
            logic [N-1:0] a, b;
            op = 3'($urandom);
            a  = N'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? N'(0) : N'($urandom);
            if ($urandom_range(0, 15) == 0) begin a = 8'h80; b = 8'hFF; end
            do_txn(op, 1'($urandom), a, b, $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
